phase1_datapath: RTL and testbench
==================================

# phase1_datapath

Phase-1 Mini-SRC datapath slice: 32-bit general registers R1–R3, PC, IR, MAR, MDR, Y and a 64-bit Z, all joined by one multiplexed 32-bit bus and a combinational ALU. A control sequencer drives the register-enable, bus-select and ALU-opcode strobes cycle by cycle to execute register-transfer steps. The memory-data input is supplied directly, and the internal nodes are exposed for waveform checking.

## Interface
- No parameters; data width fixed at 32 (Z is 64).
- Clock  in  1  single system clock; all state changes on rising edge.
- Resetn  in  1  reset is synchronous and active-low.
- R1in, R2in, R3in  in  1 each  load the matching register from bus.
- MARin, PCin, IRin, Yin  in  1 each  load MAR/PC/IR/Y from bus.
- MDRin  in  1  load MDR from its input mux.
- Zin  in  1  load Z from ALU result.
- IncrementPC  in  1  with PCin, PC increments instead of loading.
- Read  in  1  MDR input mux select: 1 = Mdatain, 0 = bus.
- PCout, ZLOout, MDRout, R2out, R3out  in  1 each  bus source selects.
- ALUControl  in  5  ALU opcode.
- Mdatain  in  32  memory read data.
- R1_data_out, R2_data_out, R3_data_out  out  32  register contents.
- big_boy_bus  out  32  current bus value (combinational).
- MDR_data_in  out  32  MDR input mux output (combinational).
- MDR_data_out, Y_data_out  out  32  register contents.
- Z_data_out  out  64  Z contents ({HI,LO}).

## Operation
- Bus mux, fixed priority when several selects are high: MDRout > PCout > ZLOout > R2out > R3out. ZLOout drives Z[31:0]. If no select is high, the bus is 0.
- MDR_data_in = Read ? Mdatain : bus.
- ALU: A = Y, B = bus. The result is 64-bit. For 32-bit ops the result goes in the low word and the high word is 0.
  - 00000 ADD A+B
  - 00001 SUB A−B
  - 00010 MUL signed 32×32→64
  - 00011 DIV signed; LO = quotient, HI = remainder; if B = 0 the result is 0
  - 00100 SHR logical A>>B[4:0]
  - 00101 SHRA arithmetic A>>>B[4:0]
  - 00110 SHL A<<B[4:0]
  - 00111 ROR A by B[4:0]
  - 01000 ROL A by B[4:0]
  - 01001 NEG −B
  - 01010 NOT ~B
  - 01011 AND A&B
  - 01100 OR A|B
  - all other codes: result 0
- Arithmetic wraps modulo 2^32 (2^64 for MUL); no flags.
- PC update: PCin & IncrementPC → PC+1; PCin alone → bus.
- IR and MAR are internal registers, not output. R1 has no bus driver.

## Timing
- Every register samples on the rising Clock edge when its enable is high, and holds otherwise.
- Bus, MDR_data_in and the ALU are combinational, so a transfer source→destination completes in one cycle.
- Z captures the ALU result from the Y value and bus value present in the same cycle.
- Reset: when Resetn = 0 at a rising edge, every register (R1–R3, PC, IR, MAR, MDR, Y, Z) goes to 0, overriding all enables. Reset asserted mid-sequence discards in-flight state.
- Reading and writing the same register in one cycle returns the old value on the bus; the new value is visible after the edge.
- Several enables may be high in one cycle; all named destinations load the same bus value.

## Test plan
- Reset: hold Resetn = 0 for one edge → all data outputs 0, big_boy_bus 0.
- Register load: Mdatain = 0x12, Read = 1, MDRin = 1 for one edge, then MDRout = 1, R2in = 1 → R2 = 0x12. Repeat with 0x14 into R3 and 0x18 into R1.
- AND sequence, starting with PC = 0:
  - T0: PCout, MARin, Zin → Z = 0.
  - T1: ZLOout, PCin, IncrementPC, Read, MDRin, Mdatain = 0x28918000 → PC = 1, MDR = 0x28918000.
  - T2: MDRout, IRin → IR = 0x28918000.
  - T3: R2out, Yin → Y = 0x12.
  - T4: R3out, ALUControl = 01011, Zin → Z = 0x10.
  - T5: ZLOout, R1in → R1 = 0x00000010.
- ALU sweep: Y = 0xFFFFFFFE, bus = 3. Expected Z per opcode:
  - ADD → 0x1
  - SUB → 0xFFFFFFFB (low word)
  - MUL → 0xFFFFFFFF_FFFFFFFA
  - DIV → LO 0, HI 0xFFFFFFFE
  - ROL → 0xFFFFFFF7
- Divide by zero: Y = 7, bus = 0, DIV → Z = 0.
- Bus priority: MDRout and R2out both high → bus equals MDR. No select high → bus = 0.

Source files
------------

// File: rtl/phase1_datapath_if.sv
// Control strobes, memory data and observable datapath nodes for the phase-1 Mini-SRC slice.
// The sequencer (or bench) is the master; the datapath is the slave.
interface phase1_datapath_if;
    logic        R1in, R2in, R3in;
    logic        MARin, PCin, IRin, Yin;
    logic        MDRin, Zin;
    logic        IncrementPC, Read;
    logic        PCout, ZLOout, MDRout, R2out, R3out;
    logic [4:0]  ALUControl;
    logic [31:0] Mdatain;

    logic [31:0] R1_data_out, R2_data_out, R3_data_out;
    logic [31:0] big_boy_bus;
    logic [31:0] MDR_data_in;
    logic [31:0] MDR_data_out, Y_data_out;
    logic [63:0] Z_data_out;

    modport master (
        output R1in, R2in, R3in, MARin, PCin, IRin, Yin, MDRin, Zin,
        output IncrementPC, Read, PCout, ZLOout, MDRout, R2out, R3out,
        output ALUControl, Mdatain,
        input  R1_data_out, R2_data_out, R3_data_out, big_boy_bus,
        input  MDR_data_in, MDR_data_out, Y_data_out, Z_data_out
    );

    modport slave (
        input  R1in, R2in, R3in, MARin, PCin, IRin, Yin, MDRin, Zin,
        input  IncrementPC, Read, PCout, ZLOout, MDRout, R2out, R3out,
        input  ALUControl, Mdatain,
        output R1_data_out, R2_data_out, R3_data_out, big_boy_bus,
        output MDR_data_in, MDR_data_out, Y_data_out, Z_data_out
    );
endinterface

// File: rtl/phase1_datapath.sv
// Phase-1 Mini-SRC datapath: register file slice, single shared 32-bit bus,
// combinational ALU feeding a 64-bit Z register.
module phase1_datapath (
    input  logic              Clock,
    input  logic              Resetn,
    phase1_datapath_if.slave  dp
);
    logic [31:0] r1_reg, r2_reg, r3_reg;
    logic [31:0] pc_reg, ir_reg, mar_reg, mdr_reg, y_reg;
    logic [63:0] z_reg;

    logic [31:0] bus;
    logic [31:0] mdr_next;
    logic [63:0] alu_result;

    // Fixed-priority bus source selection; nothing selected leaves the bus at zero.
    always_comb begin
        if (dp.MDRout)      bus = mdr_reg;
        else if (dp.PCout)  bus = pc_reg;
        else if (dp.ZLOout) bus = z_reg[31:0];
        else if (dp.R2out)  bus = r2_reg;
        else if (dp.R3out)  bus = r3_reg;
        else                bus = 32'd0;
    end

    assign mdr_next = dp.Read ? dp.Mdatain : bus;

    // ALU operands: A from Y, B from the bus.
    logic [31:0]        alu_a, alu_b;
    logic [4:0]         shamt;
    logic signed [63:0] product;
    logic signed [31:0] quotient, remainder;
    logic [63:0]        ror_wide, rol_wide;

    assign alu_a    = y_reg;
    assign alu_b    = bus;
    assign shamt    = alu_b[4:0];
    assign product  = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});
    assign ror_wide = {alu_a, alu_a} >> shamt;
    assign rol_wide = {alu_a, alu_a} << shamt;

    always_comb begin
        quotient  = 32'sd0;
        remainder = 32'sd0;
        if (alu_b != 32'd0) begin
            quotient  = $signed(alu_a) / $signed(alu_b);
            remainder = $signed(alu_a) % $signed(alu_b);
        end
    end

    always_comb begin
        alu_result = 64'd0;
        case (dp.ALUControl)
            5'b00000: alu_result = {32'd0, alu_a + alu_b};
            5'b00001: alu_result = {32'd0, alu_a - alu_b};
            5'b00010: alu_result = product;
            5'b00011: alu_result = {remainder, quotient};
            5'b00100: alu_result = {32'd0, alu_a >> shamt};
            5'b00101: alu_result = {32'd0, 32'($signed(alu_a) >>> shamt)};
            5'b00110: alu_result = {32'd0, alu_a << shamt};
            5'b00111: alu_result = {32'd0, ror_wide[31:0]};
            5'b01000: alu_result = {32'd0, rol_wide[63:32]};
            5'b01001: alu_result = {32'd0, 32'd0 - alu_b};
            5'b01010: alu_result = {32'd0, ~alu_b};
            5'b01011: alu_result = {32'd0, alu_a & alu_b};
            5'b01100: alu_result = {32'd0, alu_a | alu_b};
            default:  alu_result = 64'd0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r1_reg  <= 32'd0;
            r2_reg  <= 32'd0;
            r3_reg  <= 32'd0;
            pc_reg  <= 32'd0;
            ir_reg  <= 32'd0;
            mar_reg <= 32'd0;
            mdr_reg <= 32'd0;
            y_reg   <= 32'd0;
            z_reg   <= 64'd0;
        end else begin
            if (dp.R1in)  r1_reg  <= bus;
            if (dp.R2in)  r2_reg  <= bus;
            if (dp.R3in)  r3_reg  <= bus;
            if (dp.IRin)  ir_reg  <= bus;
            if (dp.MARin) mar_reg <= bus;
            if (dp.Yin)   y_reg   <= bus;
            if (dp.MDRin) mdr_reg <= mdr_next;
            if (dp.Zin)   z_reg   <= alu_result;
            // Increment takes precedence over the bus when both are requested.
            if (dp.PCin)  pc_reg  <= dp.IncrementPC ? pc_reg + 32'd1 : bus;
        end
    end

    assign dp.R1_data_out  = r1_reg;
    assign dp.R2_data_out  = r2_reg;
    assign dp.R3_data_out  = r3_reg;
    assign dp.big_boy_bus  = bus;
    assign dp.MDR_data_in  = mdr_next;
    assign dp.MDR_data_out = mdr_reg;
    assign dp.Y_data_out   = y_reg;
    assign dp.Z_data_out   = z_reg;
endmodule

// File: tb/tb_phase1_datapath.sv
// Directed bench for phase1_datapath: an arithmetic reference model checked every
// cycle, plus hand-computed expectations along the register-transfer sequences.
module tb_phase1_datapath;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    phase1_datapath_if dp_if ();

    phase1_datapath dut (
        .Clock  (clk),
        .Resetn (resetn),
        .dp     (dp_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: only what is observable through the bus or outputs.
    logic [31:0] m_r1, m_r2, m_r3, m_pc, m_mdr, m_y;
    logic [63:0] m_z;
    bit          model_valid = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_bus();
        if (dp_if.MDRout) return m_mdr;
        if (dp_if.PCout)  return m_pc;
        if (dp_if.ZLOout) return m_z[31:0];
        if (dp_if.R2out)  return m_r2;
        if (dp_if.R3out)  return m_r3;
        return 32'd0;
    endfunction

    // Arithmetic on wide signed integers and bit-by-bit loops for shifts/rotates.
    function automatic logic [63:0] m_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [31:0] t;
        int          n;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n  = int'(b[4:0]);
        t  = a;
        case (op)
            5'd0:  begin q = longint'(a) + longint'(b); return {32'd0, q[31:0]}; end
            5'd1:  begin q = longint'(a) - longint'(b); return {32'd0, q[31:0]}; end
            5'd2:  return sa * sb;
            5'd3:  begin
                       if (b == 0) return 64'd0;
                       q = sa / sb;
                       r = sa - q * sb;
                       return {r[31:0], q[31:0]};
                   end
            5'd4:  begin for (int i = 0; i < n; i++) t = {1'b0, t[31:1]};  return {32'd0, t}; end
            5'd5:  begin for (int i = 0; i < n; i++) t = {t[31], t[31:1]}; return {32'd0, t}; end
            5'd6:  begin for (int i = 0; i < n; i++) t = {t[30:0], 1'b0};  return {32'd0, t}; end
            5'd7:  begin for (int i = 0; i < n; i++) t = {t[0], t[31:1]};  return {32'd0, t}; end
            5'd8:  begin for (int i = 0; i < n; i++) t = {t[30:0], t[31]}; return {32'd0, t}; end
            5'd9:  begin q = -sb; return {32'd0, q[31:0]}; end
            5'd10: return {32'd0, ~b};
            5'd11: return {32'd0, a & b};
            5'd12: return {32'd0, a | b};
            default: return 64'd0;
        endcase
    endfunction

    always @(posedge clk) begin : model_update
        logic [31:0] b;
        logic [63:0] res;
        if (!resetn) begin
            m_r1 <= 0; m_r2 <= 0; m_r3 <= 0; m_pc <= 0; m_mdr <= 0; m_y <= 0; m_z <= 0;
            model_valid <= 1;
        end else begin
            b   = m_bus();
            res = m_alu(dp_if.ALUControl, m_y, b);
            if (dp_if.R1in)  m_r1  <= b;
            if (dp_if.R2in)  m_r2  <= b;
            if (dp_if.R3in)  m_r3  <= b;
            if (dp_if.Yin)   m_y   <= b;
            if (dp_if.MDRin) m_mdr <= dp_if.Read ? dp_if.Mdatain : b;
            if (dp_if.Zin)   m_z   <= res;
            if (dp_if.PCin)  m_pc  <= dp_if.IncrementPC ? m_pc + 1 : b;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("bus",    {32'd0, dp_if.big_boy_bus},  {32'd0, m_bus()});
            chk("mdr_in", {32'd0, dp_if.MDR_data_in},  {32'd0, dp_if.Read ? dp_if.Mdatain : m_bus()});
            chk("r1",     {32'd0, dp_if.R1_data_out},  {32'd0, m_r1});
            chk("r2",     {32'd0, dp_if.R2_data_out},  {32'd0, m_r2});
            chk("r3",     {32'd0, dp_if.R3_data_out},  {32'd0, m_r3});
            chk("mdr",    {32'd0, dp_if.MDR_data_out}, {32'd0, m_mdr});
            chk("y",      {32'd0, dp_if.Y_data_out},   {32'd0, m_y});
            chk("z",      dp_if.Z_data_out,            m_z);
        end
    end

    task automatic idle();
        dp_if.R1in = 0; dp_if.R2in = 0; dp_if.R3in = 0;
        dp_if.MARin = 0; dp_if.PCin = 0; dp_if.IRin = 0; dp_if.Yin = 0;
        dp_if.MDRin = 0; dp_if.Zin = 0; dp_if.IncrementPC = 0; dp_if.Read = 0;
        dp_if.PCout = 0; dp_if.ZLOout = 0; dp_if.MDRout = 0; dp_if.R2out = 0; dp_if.R3out = 0;
        dp_if.ALUControl = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        dp_if.Mdatain = v; dp_if.Read = 1; dp_if.MDRin = 1;
        tick();
    endtask

    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [4:0] OP_AND = 5'b01011;

    logic [63:0] sweep_exp [5];
    logic [4:0]  sweep_op  [5];

    initial begin
        resetn = 0;
        dp_if.Mdatain = 32'hDEAD_BEEF;
        idle();
        dp_if.R1in = 1; dp_if.Zin = 1; dp_if.PCin = 1;
        tick();
        chk("reset_r1",  {32'd0, dp_if.R1_data_out},  64'd0);
        chk("reset_mdr", {32'd0, dp_if.MDR_data_out}, 64'd0);
        chk("reset_z",   dp_if.Z_data_out,            64'd0);
        chk("reset_bus", {32'd0, dp_if.big_boy_bus},  64'd0);
        resetn = 1;

        load_mdr(32'h12); dp_if.MDRout = 1; dp_if.R2in = 1; tick();
        chk("load_r2", {32'd0, dp_if.R2_data_out}, 64'h12);
        load_mdr(32'h14); dp_if.MDRout = 1; dp_if.R3in = 1; tick();
        chk("load_r3", {32'd0, dp_if.R3_data_out}, 64'h14);
        load_mdr(32'h18); dp_if.MDRout = 1; dp_if.R1in = 1; tick();
        chk("load_r1", {32'd0, dp_if.R1_data_out}, 64'h18);

        // AND instruction, PC = 0 since reset.
        dp_if.PCout = 1; dp_if.MARin = 1; dp_if.Zin = 1; tick();
        chk("t0_z", dp_if.Z_data_out, 64'd0);
        dp_if.ZLOout = 1; dp_if.PCin = 1; dp_if.IncrementPC = 1;
        dp_if.Read = 1; dp_if.MDRin = 1; dp_if.Mdatain = 32'h2891_8000; tick();
        chk("t1_mdr", {32'd0, dp_if.MDR_data_out}, 64'h2891_8000);
        dp_if.MDRout = 1; dp_if.IRin = 1; tick();
        dp_if.R2out = 1; dp_if.Yin = 1; tick();
        chk("t3_y", {32'd0, dp_if.Y_data_out}, 64'h12);
        dp_if.R3out = 1; dp_if.ALUControl = OP_AND; dp_if.Zin = 1; tick();
        chk("t4_z", dp_if.Z_data_out, 64'h10);
        dp_if.ZLOout = 1; dp_if.R1in = 1; tick();
        chk("t5_r1", {32'd0, dp_if.R1_data_out}, 64'h10);
        dp_if.PCout = 1; #1;
        chk("pc_incr", {32'd0, dp_if.big_boy_bus}, 64'h1);
        tick();

        // ALU sweep with Y = -2, bus = 3 over every opcode.
        load_mdr(32'hFFFF_FFFE); dp_if.MDRout = 1; dp_if.Yin = 1; tick();
        load_mdr(32'd3);
        sweep_op[0] = 5'd0;  sweep_exp[0] = 64'h0000_0000_0000_0001;
        sweep_op[1] = 5'd1;  sweep_exp[1] = 64'h0000_0000_FFFF_FFFB;
        sweep_op[2] = 5'd2;  sweep_exp[2] = 64'hFFFF_FFFF_FFFF_FFFA;
        sweep_op[3] = 5'd3;  sweep_exp[3] = 64'hFFFF_FFFE_0000_0000;
        sweep_op[4] = 5'd8;  sweep_exp[4] = 64'h0000_0000_FFFF_FFF7;
        for (int op = 0; op < 32; op++) begin
            dp_if.MDRout = 1; dp_if.Zin = 1; dp_if.ALUControl = 5'(op); tick();
            for (int k = 0; k < 5; k++)
                if (sweep_op[k] == 5'(op))
                    chk($sformatf("sweep_op%0d", op), dp_if.Z_data_out, sweep_exp[k]);
        end

        // Divide by zero after a nonzero Z.
        load_mdr(32'd7); dp_if.MDRout = 1; dp_if.Yin = 1; tick();
        dp_if.MDRout = 1; dp_if.Zin = 1; tick();
        chk("add_7_7", dp_if.Z_data_out, 64'd14);
        dp_if.Zin = 1; dp_if.ALUControl = OP_DIV; tick();
        chk("div_zero", dp_if.Z_data_out, 64'd0);

        // Bus priority.
        load_mdr(32'h5A5A_0001);
        dp_if.MDRout = 1; dp_if.R2out = 1; #1;
        chk("prio_mdr_r2", {32'd0, dp_if.big_boy_bus}, 64'h5A5A_0001);
        dp_if.MDRout = 0; dp_if.PCout = 1; dp_if.ZLOout = 1; #1;
        chk("prio_pc_zlo", {32'd0, dp_if.big_boy_bus}, 64'h1);
        idle(); #1;
        chk("bus_none", {32'd0, dp_if.big_boy_bus}, 64'd0);
        tick();

        // Read and write of the same register in one cycle, with multiple destinations.
        dp_if.R3out = 1; dp_if.R3in = 1; dp_if.R2in = 1; dp_if.Yin = 1; tick();
        chk("multi_dest_r2", {32'd0, dp_if.R2_data_out}, 64'h14);
        dp_if.ZLOout = 1; dp_if.Zin = 1; dp_if.ALUControl = 5'd0; tick();
        chk("z_feedback", dp_if.Z_data_out, 64'h14);

        // Mid-sequence reset overrides enables.
        resetn = 0;
        dp_if.MDRout = 1; dp_if.R1in = 1; dp_if.R2in = 1; dp_if.Zin = 1; dp_if.Yin = 1;
        tick();
        chk("midreset_r2", {32'd0, dp_if.R2_data_out}, 64'd0);
        chk("midreset_y",  {32'd0, dp_if.Y_data_out},  64'd0);
        resetn = 1;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
